// File: rtl/rr_grant_encoder.sv
// Four-way round-robin arbiter producing a registered grant index/enable pair
// for a downstream 2-to-4 decoder. Optional forced release: define TIMEOUT_EN.
module rr_grant_encoder #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_en,
  output logic       busy,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no grant outstanding; scan req from ptr each cycle
  // GRANT | gnt_idx owns the resource until done (or forced release)
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] gnt_idx_q;
  logic       gnt_en_q;
  logic       timeout_q;

  logic [1:0] sel_d;
  logic       found;
  logic [1:0] scan_idx;

  // First set request at or after ptr_q, wrapping modulo 4.
  always_comb begin
    sel_d    = ptr_q;
    found    = 1'b0;
    scan_idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!found && req[scan_idx]) begin
        sel_d = scan_idx;
        found = 1'b1;
      end
    end
  end

`ifdef TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_idx_q <= 2'd0;
      gnt_en_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_idx_q <= sel_d;
            gnt_en_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          cnt_q <= cnt_q + 1'b1;
          // done wins over a coincident timeout, so no pulse in that case
          if (done || (cnt_q == CNT_W'(HOLD_MAX - 1))) begin
            gnt_en_q  <= 1'b0;
            ptr_q     <= gnt_idx_q + 2'd1;
            state_q   <= IDLE;
            timeout_q <= ~done;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  wire unused_cfg = (HOLD_MAX > 0) ^ (CNT_W > 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_idx_q <= 2'd0;
      gnt_en_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_idx_q <= sel_d;
            gnt_en_q  <= 1'b1;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (done) begin
            gnt_en_q <= 1'b0;
            ptr_q    <= gnt_idx_q + 2'd1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

  assign gnt_idx = gnt_idx_q;
  assign gnt_en  = gnt_en_q;
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule
